// File: rtl/prng_check.sv
// -----------------------------------------------------------------------------
// prng_check
// Receive-side checker for the prng LFSR word stream. It seeds itself from the
// first non-zero word it sees. It then confirms LOCK_CNT predictions in a row
// before it declares lock. While locked it free-runs its own copy of the
// generator (flywheel) and flags every received word that disagrees with it.
//
// Ports
//   clk        in   1      rising-edge clock
//   nRst       in   1      asynchronous active-low reset
//   valid      in   1      data carries one generator word this cycle
//   data       in   WIDTH  received generator word
//   clear      in   1      synchronous clear of err_count
//   locked     out  1      checker synchronised to the stream (registered)
//   err        out  1      one-cycle pulse, last valid word mismatched while
//                          locked (registered)
//   err_count  out  ERR_W  saturating count of locked-state mismatches
// -----------------------------------------------------------------------------
module prng_check #(
  parameter int WIDTH    = 8,
  parameter int TAP1     = 1,
  parameter int TAP2     = 0,
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count
);

  // The counters only ever hold values up to LOCK_CNT-1 / LOSS_CNT-1. The
  // terminal value is detected before the increment would reach it.
  localparam int MATCH_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;
  localparam int MISS_W  = (LOSS_CNT > 1) ? $clog2(LOSS_CNT) : 1;

  localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST  = MISS_W'(LOSS_CNT - 1);
  localparam logic [MATCH_W-1:0] MATCH_ZERO = {MATCH_W{1'b0}};
  localparam logic [MISS_W-1:0]  MISS_ZERO  = {MISS_W{1'b0}};
  localparam logic [MATCH_W-1:0] MATCH_ONE  = {{(MATCH_W-1){1'b0}}, 1'b1};
  localparam logic [MISS_W-1:0]  MISS_ONE   = {{(MISS_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]   WORD_ZERO  = {WIDTH{1'b0}};
  localparam logic [ERR_W-1:0]   CNT_ZERO   = {ERR_W{1'b0}};
  localparam logic [ERR_W-1:0]   CNT_ONE    = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [ERR_W-1:0]   CNT_MAX    = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  // One generator update: the new MSB is the tap XOR, and the rest shifts right.
  function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] w);
    return {w[TAP1] ^ w[TAP2], w[WIDTH-1:1]};
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   pred_q, pred_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_count_q, err_count_d;

  logic               is_match_s;
  logic               is_zero_s;
  logic               cnt_inc_s;

  assign is_match_s = (data == pred_q);
  assign is_zero_s  = (data == WORD_ZERO);

  // Next-state logic for acquisition, flywheel tracking and lock loss.
  always_comb begin
    state_d   = state_q;
    pred_d    = pred_q;
    match_d   = match_q;
    miss_d    = miss_q;
    locked_d  = locked_q;
    err_d     = 1'b0;
    cnt_inc_s = 1'b0;

    if (valid) begin
      case (state_q)
        SEARCH: begin
          // All-zero is the generator's stuck state, so it can never seed.
          if (!is_zero_s) begin
            pred_d  = lfsr_next(data);
            match_d = MATCH_ZERO;
            state_d = VERIFY;
          end else begin
            state_d = SEARCH;
          end
        end

        VERIFY: begin
          if (is_match_s) begin
            pred_d = lfsr_next(data);
            if (match_q == MATCH_LAST) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              match_d  = MATCH_ZERO;
              miss_d   = MISS_ZERO;
            end else begin
              match_d = match_q + MATCH_ONE;
            end
          end else if (!is_zero_s) begin
            // A wrong non-zero word is a better seed than the failed guess.
            pred_d  = lfsr_next(data);
            match_d = MATCH_ZERO;
          end else begin
            match_d = MATCH_ZERO;
            state_d = SEARCH;
          end
        end

        LOCKED: begin
          // The flywheel ignores data so corrupt words cannot derail tracking.
          pred_d = lfsr_next(pred_q);
          if (!is_match_s) begin
            err_d     = 1'b1;
            cnt_inc_s = 1'b1;
            if (miss_q == MISS_LAST) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              match_d  = MATCH_ZERO;
              miss_d   = MISS_ZERO;
            end else begin
              miss_d = miss_q + MISS_ONE;
            end
          end else begin
            miss_d = MISS_ZERO;
          end
        end

        default: begin
          state_d  = SEARCH;
          locked_d = 1'b0;
          match_d  = MATCH_ZERO;
          miss_d   = MISS_ZERO;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Error counter: a same-cycle clear keeps the new error, and increments saturate.
  always_comb begin
    err_count_d = err_count_q;
    if (clear) begin
      err_count_d = cnt_inc_s ? CNT_ONE : CNT_ZERO;
    end else if (cnt_inc_s && (err_count_q != CNT_MAX)) begin
      err_count_d = err_count_q + CNT_ONE;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State, prediction, counters and registered outputs.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= SEARCH;
      pred_q      <= WORD_ZERO;
      match_q     <= MATCH_ZERO;
      miss_q      <= MISS_ZERO;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      err_count_q <= CNT_ZERO;
    end else begin
      state_q     <= state_d;
      pred_q      <= pred_d;
      match_q     <= match_d;
      miss_q      <= miss_d;
      locked_q    <= locked_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked    = locked_q;
  assign err       = err_q;
  assign err_count = err_count_q;

endmodule
